// File: rtl/csr_spi_flash.sv
// CSR-mapped SPI master (mode 0, MSB first) for the configuration flash.
// Software writes one byte to DATA. The block shifts it out on spido while
// capturing spidi, then returns the received byte through DATA.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no transfer; spiclk low, spido holds the last bit sent
// S_LOW  | spiclk low half-period; spido carries the current bit
// S_HIGH | spiclk high half-period; spidi was sampled on entry
// S_DONE | one cycle: publish received byte, drop busy
module csr_spi_flash #(
    parameter logic [11:0] CSR_CTRL  = 12'hBC4,
    parameter logic [11:0] CSR_DATA  = 12'hBC5,
    parameter logic [7:0]  DIV_RESET = 8'd1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    output logic        spics,
    output logic        spiclk,
    output logic        spido,
    input  logic        spidi
);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    state_t      state, state_n;
    logic        ctrl_cs, cs_new;
    logic [7:0]  ctrl_div, div_new;
    logic [7:0]  cnt, cnt_n;
    logic [2:0]  bitcnt, bitcnt_n;
    logic [6:0]  tx, tx_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  rx, rx_n;
    logic        busy, busy_n;
    logic        spiclk_n, spido_n;
    logic        hit_ctrl, hit_data, launch;

    // Reads have no side effects, so the strobe and the upper operand bits are not used.
    logic [16:0] unused_bits;
    assign unused_bits = {read, wdata[31:16]};

    assign hit_ctrl = (addr == CSR_CTRL);
    assign hit_data = (addr == CSR_DATA);
    assign valid    = hit_ctrl | hit_data;
    assign launch   = hit_data && (modify != 3'b000) && (state == S_IDLE);

    // Read mux: decoded from addr alone.
    always_comb begin
        rdata = 32'h0;
        if (hit_ctrl)
            rdata = {16'h0, ctrl_div, 7'h0, ctrl_cs};
        else if (hit_data)
            rdata = {busy, 23'h0, rx};
    end

    // Next value of CTRL for write / set / clear.
    always_comb begin
        cs_new  = ctrl_cs;
        div_new = ctrl_div;
        case (modify)
            3'b001: begin
                cs_new  = wdata[0];
                div_new = wdata[15:8];
            end
            3'b010: begin
                cs_new  = ctrl_cs | wdata[0];
                div_new = ctrl_div | wdata[15:8];
            end
            3'b100: begin
                cs_new  = ctrl_cs & ~wdata[0];
                div_new = ctrl_div & ~wdata[15:8];
            end
            default: ;
        endcase
    end

    // CTRL register. spics follows cs independently of the shift engine.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_cs  <= 1'b0;
            ctrl_div <= DIV_RESET;
            spics    <= 1'b1;
        end else if (hit_ctrl) begin
            ctrl_cs  <= cs_new;
            ctrl_div <= div_new;
            spics    <= ~cs_new;
        end
    end

    // Shift engine: next state and datapath. The half-period counter counts down to zero.
    // It reloads from the live div value, so a div change applies from the next half-period.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitcnt_n = bitcnt;
        tx_n     = tx;
        shift_n  = shift;
        rx_n     = rx;
        busy_n   = busy;
        spiclk_n = spiclk;
        spido_n  = spido;
        case (state)
            S_IDLE: begin
                if (launch) begin
                    state_n  = S_LOW;
                    cnt_n    = ctrl_div;
                    bitcnt_n = 3'd0;
                    tx_n     = wdata[6:0];
                    spido_n  = wdata[7];
                    busy_n   = 1'b1;
                end
            end
            S_LOW: begin
                if (cnt == 8'd0) begin
                    state_n  = S_HIGH;
                    cnt_n    = ctrl_div;
                    spiclk_n = 1'b1;
                    shift_n  = {shift[6:0], spidi};
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_HIGH: begin
                if (cnt == 8'd0) begin
                    spiclk_n = 1'b0;
                    cnt_n    = ctrl_div;
                    if (bitcnt == 3'd7) begin
                        state_n = S_DONE;
                    end else begin
                        state_n  = S_LOW;
                        bitcnt_n = bitcnt + 3'd1;
                        spido_n  = tx[6];
                        tx_n     = {tx[5:0], 1'b0};
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_DONE: begin
                spiclk_n = 1'b0;
                rx_n     = shift;
                busy_n   = 1'b0;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and datapath registers. Reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            cnt    <= 8'd0;
            bitcnt <= 3'd0;
            tx     <= 7'd0;
            shift  <= 8'd0;
            rx     <= 8'd0;
            busy   <= 1'b0;
            spiclk <= 1'b0;
            spido  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitcnt <= bitcnt_n;
            tx     <= tx_n;
            shift  <= shift_n;
            rx     <= rx_n;
            busy   <= busy_n;
            spiclk <= spiclk_n;
            spido  <= spido_n;
        end
    end

endmodule

// File: tb/tb_csr_spi_flash.sv
// Bench for csr_spi_flash: CTRL register model, loopback, byte slave and JEDEC-ID flash model.
module tb_csr_spi_flash;

    localparam logic [11:0] A_CTRL = 12'hBC4;
    localparam logic [11:0] A_DATA = 12'hBC5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        read = 1'b0;
    logic [2:0]  modify = 3'b000;
    logic [31:0] wdata = 32'h0;
    logic [11:0] addr = 12'h0;
    logic [31:0] rdata;
    logic        valid, spics, spiclk, spido, spidi;

    int checks = 0;
    int errors = 0;

    // spi_mode: 0 loopback, 1 byte slave, 2 flash
    int          spi_mode = 0;
    logic        miso = 1'b0;
    logic [7:0]  slv_sh = 8'h0;
    int          fl_bits = 0;
    logic [7:0]  fl_cmd = 8'h0;
    logic [23:0] fl_out = 24'h0;

    // Expected CTRL contents
    logic        cm_cs = 1'b0;
    logic [7:0]  cm_div = 8'd1;

    csr_spi_flash dut (
        .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata),
        .addr(addr), .rdata(rdata), .valid(valid), .spics(spics),
        .spiclk(spiclk), .spido(spido), .spidi(spidi)
    );

    assign spidi = (spi_mode == 0) ? spido : miso;

    always #5 clk = ~clk;

    // Slaves change MISO on the falling SPI clock (mode 0).
    always @(negedge spiclk) begin
        if (spi_mode == 1) begin
            miso   = slv_sh[7];
            slv_sh = {slv_sh[6:0], 1'b0};
        end else if (spi_mode == 2 && !spics) begin
            miso   = fl_out[23];
            fl_out = {fl_out[22:0], 1'b0};
        end
    end

    always @(negedge spics) begin
        fl_bits = 0;
        fl_cmd  = 8'h0;
        fl_out  = 24'h0;
        if (spi_mode == 2) miso = 1'b0;
    end

    always @(posedge spiclk) begin
        if (spi_mode == 2 && !spics && fl_bits < 8) begin
            fl_cmd = {fl_cmd[6:0], spido};
            fl_bits++;
            if (fl_bits == 8 && fl_cmd == 8'h9F) fl_out = 24'hEF4016;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic ctrl_op(input logic [2:0] m, input logic [31:0] wd);
        logic [31:0] old_v, new_v;
        old_v = {16'h0, cm_div, 7'h0, cm_cs};
        case (m)
            3'b001:  new_v = wd;
            3'b010:  new_v = old_v | wd;
            3'b100:  new_v = old_v & ~wd;
            default: new_v = old_v;
        endcase
        cm_cs  = new_v[0];
        cm_div = new_v[15:8];
        @(negedge clk);
        addr = A_CTRL; modify = m; wdata = wd;
        @(negedge clk);
        modify = 3'b000;
        #1;
    endtask

    // One byte transfer, checked against the expected waveform. A write of 3C is injected after inject_at busy cycles.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] exp_rx, input int inject_at, input string name);
        int h, n, rises, bad;
        logic prev, e;
        logic [7:0] mosi_seen;
        logic q[$];
        logic [2:0] m;
        h = int'(cm_div) + 1;
        case ($urandom_range(0, 2))
            0:       m = 3'b001;
            1:       m = 3'b010;
            default: m = 3'b100;
        endcase
        @(negedge clk);
        addr = A_DATA; modify = m; wdata = $urandom; wdata[7:0] = tx;
        #1;
        checks++;
        if (rdata[31] !== 1'b0) begin
            errors++;
            $display("FAIL %s launch_busy got %b exp 0", name, rdata[31]);
        end
        @(negedge clk);
        modify = 3'b000;
        #1;
        n = 0; rises = 0; prev = 1'b0; mosi_seen = 8'h0;
        while (rdata[31] === 1'b1 && n < 5000) begin
            n++;
            q.push_back(spiclk);
            if (spiclk && !prev) begin
                rises++;
                mosi_seen = {mosi_seen[6:0], spido};
            end
            prev = spiclk;
            if (n == inject_at) begin
                modify = 3'b001; wdata = 32'h3C;
            end else begin
                modify = 3'b000;
            end
            @(negedge clk);
            #1;
        end
        modify = 3'b000;
        checks++;
        if (n != 16 * h + 1) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d exp %0d", name, n, 16 * h + 1);
        end
        bad = 0;
        for (int i = 0; i < q.size(); i++) begin
            e = (i < 16 * h) ? logic'((i / h) % 2) : 1'b0;
            if (q[i] !== e) bad++;
        end
        checks++;
        if (bad != 0 || rises != 8) begin
            errors++;
            $display("FAIL %s spiclk_shape got %0d bad samples %0d rises exp 0 bad 8 rises", name, bad, rises);
        end
        checks++;
        if (mosi_seen !== tx) begin
            errors++;
            $display("FAIL %s mosi got %h exp %h", name, mosi_seen, tx);
        end
        checks++;
        if (rdata[7:0] !== exp_rx) begin
            errors++;
            $display("FAIL %s rx got %h exp %h", name, rdata[7:0], exp_rx);
        end
        checks++;
        if (spiclk !== 1'b0 || spido !== tx[0]) begin
            errors++;
            $display("FAIL %s idle_pins got clk %b do %b exp clk 0 do %b", name, spiclk, spido, tx[0]);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #12;
        checks++;
        if ({spics, spiclk, spido} !== 3'b100) begin
            errors++;
            $display("FAIL reset_pins got %b exp 100", {spics, spiclk, spido});
        end
        addr = A_CTRL; #1;
        checks++;
        if (rdata !== 32'h0000_0100 || valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl got %h/%b exp 00000100/1", rdata, valid);
        end
        addr = A_DATA; #1;
        checks++;
        if (rdata !== 32'h0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_data got %h/%b exp 0/1", rdata, valid);
        end
        addr = 12'h123; #1;
        checks++;
        if (rdata !== 32'h0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL other_addr got %h/%b exp 0/0", rdata, valid);
        end
        @(negedge clk);
        rstn = 1'b1;
        cm_cs = 1'b0; cm_div = 8'd1;
    endtask

    task automatic test_ctrl_ops;
        logic [2:0] m;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0:       m = 3'b001;
                1:       m = 3'b010;
                default: m = 3'b100;
            endcase
            ctrl_op(m, $urandom);
            checks++;
            if (rdata !== {16'h0, cm_div, 7'h0, cm_cs} || spics !== ~cm_cs) begin
                errors++;
                $display("FAIL ctrl_op%0d got %h spics %b exp %h spics %b", i, rdata, spics,
                         {16'h0, cm_div, 7'h0, cm_cs}, ~cm_cs);
            end
        end
        ctrl_op(3'b001, 32'h0);
    endtask

    task automatic test_loopback_a5;
        spi_mode = 0;
        ctrl_op(3'b001, 32'h0);
        xfer(8'hA5, 8'hA5, 0, "loop_a5");
    endtask

    task automatic test_jedec;
        miso = 1'b0;
        spi_mode = 2;
        ctrl_op(3'b001, 32'h0000_0101);
        checks++;
        if (spics !== 1'b0) begin
            errors++;
            $display("FAIL jedec_cs_on got %b exp 0", spics);
        end
        xfer(8'h9F, 8'h00, 0, "jedec_cmd");
        xfer(8'h00, 8'hEF, 0, "jedec_mfr");
        xfer(8'h00, 8'h40, 0, "jedec_type");
        xfer(8'h00, 8'h16, 0, "jedec_cap");
        ctrl_op(3'b100, 32'h1);
        checks++;
        if (spics !== 1'b1) begin
            errors++;
            $display("FAIL jedec_cs_off got %b exp 1", spics);
        end
        spi_mode = 0;
    endtask

    task automatic test_busy_write;
        logic [7:0] sb, tx;
        sb = 8'($urandom); tx = 8'($urandom);
        ctrl_op(3'b001, {16'h0, 8'($urandom_range(0, 2)), 8'h0});
        spi_mode = 1; miso = sb[7]; slv_sh = {sb[6:0], 1'b0};
        xfer(tx, sb, 5, "busy_write");
        spi_mode = 0;
    endtask

    task automatic test_div3;
        logic [7:0] tx;
        tx = 8'($urandom);
        spi_mode = 0;
        ctrl_op(3'b001, 32'h0000_0300);
        xfer(tx, tx, 0, "div3");
    endtask

    task automatic test_random;
        logic [7:0] sb, tx;
        for (int i = 0; i < 6; i++) begin
            sb = 8'($urandom); tx = 8'($urandom);
            ctrl_op(3'b001, {16'h0, 8'($urandom_range(0, 3)), 7'h0, 1'($urandom)});
            spi_mode = 1; miso = sb[7]; slv_sh = {sb[6:0], 1'b0};
            xfer(tx, sb, 0, $sformatf("rand%0d", i));
        end
        spi_mode = 0;
    endtask

    task automatic test_cs_clear_busy;
        logic [7:0] sb;
        int n;
        sb = 8'($urandom);
        ctrl_op(3'b001, 32'h0000_0001);
        spi_mode = 1; miso = sb[7]; slv_sh = {sb[6:0], 1'b0};
        @(negedge clk);
        addr = A_DATA; modify = 3'b001; wdata = 32'h5A;
        @(negedge clk);
        modify = 3'b000;
        repeat (3) @(negedge clk);
        addr = A_CTRL; modify = 3'b100; wdata = 32'h1;
        cm_cs = 1'b0;
        @(negedge clk);
        modify = 3'b000; addr = A_DATA;
        #1;
        checks++;
        if (spics !== 1'b1 || rdata[31] !== 1'b1) begin
            errors++;
            $display("FAIL cs_clear got spics %b busy %b exp 1 1", spics, rdata[31]);
        end
        n = 0;
        while (rdata[31] === 1'b1 && n < 500) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (rdata[31] !== 1'b0 || rdata[7:0] !== sb) begin
            errors++;
            $display("FAIL cs_clear_rx got %h busy %b exp %h busy 0", rdata[7:0], rdata[31], sb);
        end
        spi_mode = 0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] tx2;
        int n, rises;
        logic prev;
        tx2 = 8'($urandom);
        spi_mode = 0;
        ctrl_op(3'b001, 32'h0000_0101);
        @(negedge clk);
        addr = A_DATA; modify = 3'b001; wdata = 32'hC3;
        @(negedge clk);
        modify = 3'b000;
        n = 0; rises = 0; prev = 1'b0;
        while (n < 200) begin
            #1;
            if (spiclk && !prev) rises++;
            prev = spiclk;
            if (rises == 5) break;
            @(negedge clk);
            n++;
        end
        checks++;
        if (rises != 5) begin
            errors++;
            $display("FAIL reset_mid_reach got %0d rises exp 5", rises);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (spiclk !== 1'b0 || spics !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pins got clk %b cs %b exp 0 1", spiclk, spics);
        end
        cm_cs = 1'b0; cm_div = 8'd1;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_data got %h exp 0", rdata);
        end
        xfer(tx2, tx2, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_ctrl_ops();
        test_loopback_a5();
        test_jedec();
        test_busy_write();
        test_div3();
        test_random();
        test_cs_clear_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
